// File: rtl/neuron_pkg.sv
// Shared constants and types for the neuron front-end and its neighbours.
package neuron_pkg;

    localparam int PIX_W    = 10;  // unsigned pixel width
    localparam int WGT_W    = 19;  // weight width, used by the neuron/weight logic
    localparam int OUT_W    = 26;  // two's-complement dot-product width
    localparam int N_PIX    = 32;  // pixels per evaluation
    localparam int IV_HOLD  = 10;  // cycles Input_valid is held per evaluation
    localparam int WAIT_MAX = 64;  // cycles to wait for an Output_valid rising edge

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        FIRE   = 2'd1,
        WAIT   = 2'd2,
        RESULT = 2'd3
    } state_e;

endpackage

// File: rtl/neuron_driver_if.sv
// Pixel stream in and result stream out of the neuron driver.
// The slave view is the driver itself; the master view is its environment.
interface neuron_driver_if
    import neuron_pkg::*;
#(
    parameter int PIX_W = neuron_pkg::PIX_W,
    parameter int OUT_W = neuron_pkg::OUT_W
);

    logic [PIX_W-1:0] pix_in;
    logic             pix_in_valid;
    logic             pix_in_ready;
    logic [OUT_W-1:0] res_out;
    logic             res_valid;
    logic             res_ready;

    modport master (
        output pix_in, pix_in_valid, res_ready,
        input  pix_in_ready, res_out, res_valid
    );

    modport slave (
        input  pix_in, pix_in_valid, res_ready,
        output pix_in_ready, res_out, res_valid
    );

endinterface

// File: rtl/neuron_pix_buffer.sv
// N x W pixel register file: one indexed write per cycle, whole contents
// exposed as a flat read bus (slot k at bits [W*k +: W]).
module neuron_pix_buffer
    import neuron_pkg::*;
#(
    parameter  int N     = N_PIX,
    parameter  int W     = PIX_W,
    localparam int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             GlobalReset,
    input  logic             we_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [W-1:0]     data_i,
    output logic [N*W-1:0]   rd_bus_o
);

    logic [N*W-1:0] mem_q;

    // Store the accepted pixel into its slot; whole buffer clears on reset.
    // NOTE: this storage is reset on purpose because the neuron sees it
    // directly and a known all-zero bus is required after reset; plain RAM
    // arrays without that need should be left unreset.
    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            mem_q <= '0;
        end else if (we_i) begin
            mem_q[idx_i*W +: W] <= data_i;
        end
    end

    assign rd_bus_o = mem_q;

endmodule

// File: rtl/neuron_driver.sv
// Front-end sequencer for one neuron: gathers a serial pixel stream into a
// parallel bus, pulses Input_valid for a fixed window, captures Out on the
// Output_valid rising edge and hands the result downstream via valid/ready.
module neuron_driver
    import neuron_pkg::*;
#(
    parameter int N_PIX    = neuron_pkg::N_PIX,
    parameter int PIX_W    = neuron_pkg::PIX_W,
    parameter int OUT_W    = neuron_pkg::OUT_W,
    parameter int IV_HOLD  = neuron_pkg::IV_HOLD,
    parameter int WAIT_MAX = neuron_pkg::WAIT_MAX
) (
    input  logic                   clk,
    input  logic                   GlobalReset,
    neuron_driver_if.slave         bus,
    output logic [N_PIX*PIX_W-1:0] nrn_pix,
    output logic                   nrn_input_valid,
    input  logic [OUT_W-1:0]       nrn_out,
    input  logic                   nrn_output_valid,
    output logic                   timeout
);

    localparam int IDX_W  = $clog2(N_PIX);
    localparam int HOLD_W = $clog2(IV_HOLD + 1);
    localparam int WAIT_W = $clog2(WAIT_MAX + 1);

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_PIX - 1);
    localparam logic [HOLD_W-1:0] LAST_HOLD = HOLD_W'(IV_HOLD - 1);
    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(WAIT_MAX - 1);

    state_e            state_q;
    logic [IDX_W-1:0]  idx_q;
    logic [HOLD_W-1:0] hold_q;
    logic [WAIT_W-1:0] wait_q;
    logic              ready_q;
    logic              iv_q;
    logic              res_valid_q;
    logic [OUT_W-1:0]  res_q;
    logic              timeout_q;
    logic              ov_q;
    logic              accept;
    logic              ov_rise;

    // ready_q is high exactly while in LOAD, so it doubles as the state gate.
    assign accept  = ready_q && bus.pix_in_valid;
    // A level left high from an earlier run never counts; only a fresh rise does.
    assign ov_rise = nrn_output_valid && !ov_q;

    neuron_pix_buffer #(
        .N (N_PIX),
        .W (PIX_W)
    ) u_buf (
        .clk         (clk),
        .GlobalReset (GlobalReset),
        .we_i        (accept),
        .idx_i       (idx_q),
        .data_i      (bus.pix_in),
        .rd_bus_o    (nrn_pix)
    );

    // Delay Output_valid by one cycle in every state for rising-edge detection.
    // NOTE: sequential state is always written with <= so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            ov_q <= 1'b0;
        end else begin
            ov_q <= nrn_output_valid;
        end
    end

    // Sequencer: LOAD -> FIRE -> WAIT -> RESULT (or back to LOAD on timeout),
    // with every externally visible control bit registered here.
    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            state_q     <= LOAD;
            idx_q       <= '0;
            hold_q      <= '0;
            wait_q      <= '0;
            ready_q     <= 1'b1;
            iv_q        <= 1'b0;
            res_valid_q <= 1'b0;
            res_q       <= '0;
            timeout_q   <= 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (accept) begin
                        if (idx_q == LAST_IDX) begin
                            idx_q   <= '0;
                            hold_q  <= '0;
                            ready_q <= 1'b0;
                            iv_q    <= 1'b1;
                            state_q <= FIRE;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                FIRE: begin
                    if (hold_q == LAST_HOLD) begin
                        iv_q    <= 1'b0;
                        wait_q  <= '0;
                        state_q <= WAIT;
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                WAIT: begin
                    if (ov_rise) begin
                        res_q       <= nrn_out;
                        res_valid_q <= 1'b1;
                        state_q     <= RESULT;
                    end else if (wait_q == LAST_WAIT) begin
                        // The neuron never answered: flag it and drop this run.
                        timeout_q <= 1'b1;
                        ready_q   <= 1'b1;
                        state_q   <= LOAD;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                RESULT: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        ready_q     <= 1'b1;
                        state_q     <= LOAD;
                    end
                end
                default: begin
                    state_q <= LOAD;
                end
            endcase
        end
    end

    assign bus.pix_in_ready = ready_q;
    assign bus.res_valid    = res_valid_q;
    assign bus.res_out      = res_q;
    assign nrn_input_valid  = iv_q;
    assign timeout          = timeout_q;

endmodule

// File: tb/tb_neuron_driver.sv
// Self-checking bench for neuron_driver: a behavioural neuron answers each
// Input_valid window, and a scoreboard of sent pixels and expected results
// is compared against the DUT outputs on falling clock edges.
module tb_neuron_driver;
    import neuron_pkg::*;

    localparam int NP       = 32;
    localparam int PW       = 10;
    localparam int OW       = 26;
    localparam int HOLD     = 10;
    localparam int WMAX     = 64;
    localparam int OV_DELAY = 30;

    typedef enum int {M_NORMAL, M_NEVER, M_STUCK} nrn_mode_e;

    logic             clk = 1'b0;
    logic             GlobalReset = 1'b1;
    logic [NP*PW-1:0] nrn_pix;
    logic             nrn_input_valid;
    logic [OW-1:0]    nrn_out = '0;
    logic             nrn_output_valid = 1'b0;
    logic             timeout;

    neuron_driver_if #(.PIX_W(PW), .OUT_W(OW)) bus ();

    neuron_driver #(
        .N_PIX    (NP),
        .PIX_W    (PW),
        .OUT_W    (OW),
        .IV_HOLD  (HOLD),
        .WAIT_MAX (WMAX)
    ) dut (
        .clk              (clk),
        .GlobalReset      (GlobalReset),
        .bus              (bus.slave),
        .nrn_pix          (nrn_pix),
        .nrn_input_valid  (nrn_input_valid),
        .nrn_out          (nrn_out),
        .nrn_output_valid (nrn_output_valid),
        .timeout          (timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- behavioural neuron ----------------
    nrn_mode_e     nrn_mode = M_NORMAL;
    int            ov_cnt = 0;
    logic          iv_prev = 1'b0;
    logic [OW-1:0] model_out = '0;
    int            ov_raise_cyc = 0;

    always @(negedge clk) begin
        if (ov_cnt != 0) begin
            ov_cnt = ov_cnt - 1;
            if (ov_cnt == 0) begin
                nrn_output_valid = 1'b1;
                nrn_out          = model_out;
                ov_raise_cyc     = cyc;
            end
        end else if (nrn_mode != M_STUCK) begin
            nrn_output_valid = 1'b0;
        end
        if (iv_prev && !nrn_input_valid && nrn_mode != M_NEVER) ov_cnt = OV_DELAY;
        iv_prev = nrn_input_valid;
    end

    // ---------------- scoreboard + checking ----------------
    logic [PW-1:0] exp_pix [NP];
    logic          exp_timeout = 1'b0;
    int            n_total = 0;
    int            n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_pix(input string tag);
        for (int k = 0; k < NP; k++)
            check($sformatf("%s[%0d]", tag, k), 64'(nrn_pix[k*PW +: PW]), 64'(exp_pix[k]));
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        GlobalReset      = 1'b1;
        bus.pix_in_valid = 1'b0;
        bus.res_ready    = 1'b0;
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 64'(bus.pix_in_ready), 1);
        check("rst_iv", 64'(nrn_input_valid), 0);
        check("rst_res_valid", 64'(bus.res_valid), 0);
        check("rst_res_out", 64'(bus.res_out), 0);
        check("rst_timeout", 64'(timeout), 0);
        for (int k = 0; k < NP; k++) exp_pix[k] = '0;
        check_all_pix("rst_pix");
        GlobalReset = 1'b0;
        exp_timeout = 1'b0;
    endtask

    // Send NP pixels (ramp 0..NP-1 or random), optionally with idle gaps.
    // Returns right after driving the last beat; it is taken on the next edge.
    task automatic load_pixels(input bit ramp, input bit gaps);
        int k = 0;
        int last_k = -1;
        logic [PW-1:0] v;
        while (k < NP) begin
            @(negedge clk);
            if (last_k >= 0) begin
                check("pix_visible", 64'(nrn_pix[last_k*PW +: PW]), 64'(exp_pix[last_k]));
                last_k = -1;
            end
            check("load_ready", 64'(bus.pix_in_ready), 1);
            if (gaps && $urandom_range(3) == 0) begin
                bus.pix_in_valid = 1'b0;
                bus.pix_in       = PW'($urandom);
            end else begin
                v = ramp ? PW'(k) : PW'($urandom);
                exp_pix[k]       = v;
                bus.pix_in       = v;
                bus.pix_in_valid = 1'b1;
                last_k           = k;
                k++;
            end
        end
    endtask

    // Follow one evaluation from FIRE entry to either a delivered result or a
    // timeout, spraying ignored pixel beats while the driver is busy.
    task automatic run_eval(input string tag, input bit expect_result, input int ready_delay);
        int iv_cnt = 0;
        int wait_cnt = 0;
        bit got = 1'b0;
        bit back = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (c == 0) begin
                check_all_pix({tag, "_fire_pix"});
                check({tag, "_fire_ready"}, 64'(bus.pix_in_ready), 0);
            end
            if (bus.res_valid) begin got = 1'b1; break; end
            if (bus.pix_in_ready) begin back = 1'b1; break; end
            if (nrn_input_valid) iv_cnt++;
            else wait_cnt++;
            bus.pix_in_valid = 1'($urandom_range(1));
            bus.pix_in       = PW'($urandom);
        end
        bus.pix_in_valid = 1'b0;
        check({tag, "_iv_len"}, 64'(iv_cnt), HOLD);
        check({tag, "_got_result"}, 64'(got), 64'(expect_result));
        if (expect_result && got) begin
            check({tag, "_res_latency"}, 64'(cyc - ov_raise_cyc), 1);
            check({tag, "_res_out"}, 64'(bus.res_out), 64'(model_out));
            check({tag, "_ready_busy"}, 64'(bus.pix_in_ready), 0);
            for (int d = 0; d < ready_delay; d++) begin
                bus.pix_in_valid = 1'b1;
                bus.pix_in       = PW'($urandom);
                @(negedge clk);
                check({tag, "_hold_valid"}, 64'(bus.res_valid), 1);
                check({tag, "_hold_out"}, 64'(bus.res_out), 64'(model_out));
            end
            bus.pix_in_valid = 1'b0;
            bus.res_ready    = 1'b1;
            @(negedge clk);
            bus.res_ready = 1'b0;
            check({tag, "_hs_valid"}, 64'(bus.res_valid), 0);
            check({tag, "_hs_ready"}, 64'(bus.pix_in_ready), 1);
        end else if (!expect_result) begin
            check({tag, "_back_to_load"}, 64'(back), 1);
            check({tag, "_wait_len"}, 64'(wait_cnt), WMAX);
            exp_timeout = 1'b1;
        end
        check({tag, "_timeout"}, 64'(timeout), 64'(exp_timeout));
        check_all_pix({tag, "_kept_pix"});
    endtask

    initial begin
        int n_iv;
        bus.pix_in       = '0;
        bus.pix_in_valid = 1'b0;
        bus.res_ready    = 1'b0;

        // Reset, then the directed ramp run with a 5-cycle stalled handshake.
        do_reset(2);
        nrn_mode  = M_NORMAL;
        model_out = 26'h3FFF0A0;
        load_pixels(1'b1, 1'b0);
        run_eval("dir", 1'b1, 5);

        // Back-to-back random evaluations.
        for (int r = 0; r < 4; r++) begin
            model_out = OW'($urandom);
            load_pixels(1'b0, 1'b1);
            run_eval($sformatf("rnd%0d", r), 1'b1, $urandom_range(3));
        end

        // Neuron never answers: timeout, no result.
        do_reset(2);
        nrn_mode = M_NEVER;
        load_pixels(1'b0, 1'b1);
        run_eval("never", 1'b0, 0);

        // Output_valid left high from the previous run is not a new edge.
        do_reset(2);
        nrn_mode  = M_STUCK;
        model_out = OW'($urandom);
        load_pixels(1'b0, 1'b0);
        run_eval("stuck_first", 1'b1, 1);
        load_pixels(1'b0, 1'b1);
        run_eval("stuck_level", 1'b0, 0);

        // Reset during the 4th FIRE cycle, then a clean evaluation.
        nrn_mode = M_NEVER;
        load_pixels(1'b0, 1'b0);
        n_iv = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            bus.pix_in_valid = 1'b0;
            if (nrn_input_valid) n_iv++;
            if (n_iv == 4) break;
        end
        check("fire4_reached", 64'(n_iv), 4);
        GlobalReset = 1'b1;
        @(negedge clk);
        check("midrst_iv", 64'(nrn_input_valid), 0);
        check("midrst_ready", 64'(bus.pix_in_ready), 1);
        check("midrst_res_valid", 64'(bus.res_valid), 0);
        check("midrst_timeout", 64'(timeout), 0);
        for (int k = 0; k < NP; k++) exp_pix[k] = '0;
        check_all_pix("midrst_pix");
        GlobalReset = 1'b0;
        exp_timeout = 1'b0;
        nrn_mode    = M_NORMAL;
        model_out   = OW'($urandom);
        load_pixels(1'b0, 1'b1);
        run_eval("post_rst", 1'b1, 2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/neuron_driver.md
# neuron_driver

Front-end sequencer that feeds one `Neuron` and collects its dot-product result. It gathers a serial stream of 32 pixels and presents them as a stable parallel bus. It then drives the neuron's `Input_valid` for a fixed hold window and captures `Out` on the neuron's `Output_valid` rising edge. Finally it returns the signed result over a valid/ready handshake. Weights are not handled here; they are wired to the neuron directly.

## Interface
Parameters:
- `N_PIX`, 32, pixels per neuron evaluation
- `PIX_W`, 10, pixel width (unsigned)
- `OUT_W`, 26, neuron result width (two's complement)
- `IV_HOLD`, 10, cycles `nrn_input_valid` is held high per evaluation
- `WAIT_MAX`, 64, max cycles to wait for the `Output_valid` rising edge

Ports:
- `clk` in 1: single clock, all logic on posedge
- `GlobalReset` in 1: synchronous, active-high reset
- `pix_in` in PIX_W: serial pixel data
- `pix_in_valid` in 1: pixel present
- `pix_in_ready` out 1: driver accepts a pixel this cycle
- `nrn_pix` out N_PIX*PIX_W: parallel pixels; `Pix_k` = bits [PIX_W*k+PIX_W-1 : PIX_W*k]
- `nrn_input_valid` out 1: to neuron `Input_valid`
- `nrn_out` in OUT_W: from neuron `Out`
- `nrn_output_valid` in 1: from neuron `Output_valid`
- `res_out` out OUT_W: captured result
- `res_valid` out 1: result available
- `res_ready` in 1: downstream accepts result
- `timeout` out 1: sticky, set when a wait expires

## Operation
- FSM states: LOAD, FIRE, WAIT, RESULT.
- Reset values: state LOAD, pixel buffer all 0, index 0, `pix_in_ready`=1, `nrn_input_valid`=0, `res_valid`=0, `res_out`=0, `timeout`=0, `ov_q`=0.
- LOAD:
  - `pix_in_ready`=1.
  - Each `pix_in_valid && pix_in_ready` beat writes buffer[idx] and increments idx (5-bit).
  - The beat with idx==N_PIX-1 wraps idx to 0 and moves to FIRE.
  - `nrn_pix` shows buffer contents at all times.
- FIRE:
  - `pix_in_ready`=0 and `nrn_input_valid`=1 for exactly IV_HOLD cycles, counted by the hold counter.
  - After the last hold cycle, the FSM moves to WAIT.
- WAIT:
  - `nrn_input_valid`=0 and the wait timer counts up.
  - On a rising edge (`nrn_output_valid && !ov_q`), `res_out` <= `nrn_out` and the FSM moves to RESULT.
  - If the timer reaches WAIT_MAX with no edge, `timeout` <= 1, the result is discarded, and the FSM returns to LOAD.
- RESULT:
  - `res_valid`=1; `res_out` is held stable until `res_valid && res_ready`.
  - The FSM then returns to LOAD.
- `ov_q` registers `nrn_output_valid` every cycle, in all states.
- A level-high `Output_valid` left over from a previous run is not an edge. The neuron must drop it before a new result is taken.
- The pixel buffer is not cleared between evaluations; every slot is overwritten in LOAD.
- `res_out` passes through unchanged (no extension or saturation); sign is interpreted downstream.
- `timeout` clears only on `GlobalReset`.

## Timing
- Pixel accept: the beat at edge t is visible on `nrn_pix` at t+1.
- After the 32nd accept at edge t:
  - FIRE begins at t+1.
  - `nrn_input_valid` is high for cycles t+1 .. t+IV_HOLD.
  - WAIT begins at t+IV_HOLD+1.
- `nrn_pix` is constant from FIRE entry until the next LOAD accept.
- Edge detected at edge e: `res_valid`=1 and `res_out` valid from e+1.
- Handshake at edge h: `res_valid`=0 and `pix_in_ready`=1 from h+1.
- Throughput: back-to-back evaluations need no idle cycles beyond the FSM transitions.
- `GlobalReset` at any edge, including mid-FIRE or mid-RESULT, forces all reset values at that edge. `nrn_input_valid` drops the same cycle, and an in-flight result is lost.
- `pix_in_valid` outside LOAD is ignored (no accept, no buffer change).

## Structure
- Shared package `neuron_pkg`:
  - constants PIX_W=10, WGT_W=19, OUT_W=26, N_PIX=32 (WGT_W is shared with the neuron/weight logic; unused here)
  - state enum {LOAD, FIRE, WAIT, RESULT}
- Sub-module `neuron_pix_buffer`:
  - N_PIX×PIX_W register file with write-enable and index, synchronous reset to 0
  - flattened read bus output
- Top level holds the FSM, hold counter, wait timer, edge detector and result register.

## Test plan
- Reset: assert `GlobalReset` 2 cycles -> all outputs at reset values; `pix_in_ready`=1.
- Load 0..31 with continuous valid, using a behavioural neuron model that pulses `Output_valid` 30 cycles after `Input_valid` falls with `Out`=26'h3FFF0A0 -> `nrn_input_valid` high exactly 10 cycles; `nrn_pix` Pix_k==k; `res_out`=26'h3FFF0A0 one cycle after the edge.
- Hold `res_ready`=0 for 5 cycles -> `res_out`/`res_valid` stable; `pix_in_valid` ignored; on `res_ready`=1 return to LOAD next cycle.
- Model never pulses `Output_valid` -> `timeout`=1 after 64 WAIT cycles, FSM in LOAD, `res_valid` never asserted.
- Model holds `Output_valid` high from the prior run into WAIT and never drops it -> no capture; timeout.
- Assert `GlobalReset` on FIRE cycle 4 -> `nrn_input_valid`=0 next cycle and buffer zeroed; a fresh 32-pixel load then completes normally.
